// File: rtl/lcd_seq_pkg.sv
// ---------------------------------------------------------------------------
// lcd_seq_pkg
// Shared constants for the LCD page sequencer:
//   - top FSM state encoding (legacy-style localparam constants)
//   - HD44780 init command list and line-address commands
//   - frame item layout (34 items: cmd 0x80, 16 chars, cmd 0xC0, 16 chars)
//   - item_char_addr(): maps a frame item index to its {line, col} address
// ---------------------------------------------------------------------------
package lcd_seq_pkg;

  // Top FSM states
  localparam logic [2:0] ST_INIT        = 3'd0;
  localparam logic [2:0] ST_IDLE        = 3'd1;
  localparam logic [2:0] ST_FRAME_START = 3'd2;
  localparam logic [2:0] ST_ISSUE       = 3'd3;
  localparam logic [2:0] ST_WAIT        = 3'd4;
  localparam logic [2:0] ST_DELAY       = 3'd5;
  localparam logic [2:0] ST_NEXT        = 3'd6;

  localparam int INIT_ITEMS  = 4;
  localparam int FRAME_ITEMS = 34;

  // HD44780 commands
  localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;  // increment, no shift
  localparam logic [7:0] CMD_LINE0        = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] CMD_LINE1        = 8'hC0;  // DDRAM address 0x40

  // Entry 0 is sent first.
  localparam logic [INIT_ITEMS-1:0][7:0] INIT_CMDS =
    {CMD_ENTRY_MODE, CMD_CLEAR, CMD_DISPLAY_ON, CMD_FUNCTION_SET};

  localparam logic [5:0] INIT_LAST  = 6'(INIT_ITEMS - 1);
  localparam logic [5:0] ITEM_LINE0 = 6'd0;
  localparam logic [5:0] ITEM_LINE1 = 6'd17;
  localparam logic [5:0] ITEM_LAST  = 6'(FRAME_ITEMS - 1);

  typedef struct packed {
    logic       rs;
    logic [7:0] data;
  } lcd_item_t;

  // Items 1..16 -> addr 0..15 (top line), items 18..33 -> addr 16..31.
  // Command items return a harmless neighbouring address.
  function automatic logic [4:0] item_char_addr(input logic [5:0] idx);
    logic [5:0] a;
    if (idx > ITEM_LINE1)
      a = idx - 6'd2;
    else if (idx != ITEM_LINE0)
      a = idx - 6'd1;
    else
      a = 6'd0;
    return a[4:0];
  endfunction

endpackage

// File: rtl/lcd_page_sequencer_if.sv
// ---------------------------------------------------------------------------
// lcd_page_sequencer_if
// Bundles the LCD_Controller handshake and the page content table lookup.
//   page       : page latched at frame start (content table index)
//   char_addr  : {line, col} of the character being fetched
//   char_code  : ASCII returned by the content table (combinational)
//   lcd_data   : to LCD_Controller iDATA
//   lcd_rs     : 0 = command, 1 = data
//   lcd_start  : to LCD_Controller iStart
//   lcd_done   : from LCD_Controller oDone
// master = sequencer side, slave = controller/content-table side.
// ---------------------------------------------------------------------------
interface lcd_page_sequencer_if;
  logic [2:0] page;
  logic [4:0] char_addr;
  logic [7:0] char_code;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_start;
  logic       lcd_done;

  modport master (
    output page, char_addr, lcd_data, lcd_rs, lcd_start,
    input  char_code, lcd_done
  );

  modport slave (
    input  page, char_addr, lcd_data, lcd_rs, lcd_start,
    output char_code, lcd_done
  );
endinterface

// File: rtl/lcd_item_handshake.sv
// ---------------------------------------------------------------------------
// lcd_item_handshake
// Runs one LCD item: on go, registers data/RS and raises lcd_start; holds
// them until lcd_done, then waits DLY_CYCLES settle cycles. item_done is high
// in the last settle cycle so the caller can advance on the following cycle.
// Ports:
//   iCLK, iRST_N        clock, asynchronous active-low reset
//   go                  start an item (accepted only when not busy)
//   data, rs            item contents, sampled in the go cycle
//   lcd_done            controller completion; ignored outside the wait phase
//   lcd_data, lcd_rs    registered controller inputs
//   lcd_start           registered controller start
//   busy                an item is in flight
//   item_done           last cycle of the settle delay
// ---------------------------------------------------------------------------
module lcd_item_handshake #(
  parameter int DLY_CYCLES = 262143
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       go,
  input  logic [7:0] data,
  input  logic       rs,
  input  logic       lcd_done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_start,
  output logic       busy,
  output logic       item_done
);

  localparam logic [1:0]  HS_IDLE  = 2'd0;
  localparam logic [1:0]  HS_WAIT  = 2'd1;
  localparam logic [1:0]  HS_DELAY = 2'd2;
  localparam logic [17:0] DLY_LAST = 18'(DLY_CYCLES - 1);

  logic [1:0]  phase_reg, phase_next;
  logic [17:0] dly_cnt_reg, dly_cnt_next;
  logic [7:0]  data_reg, data_next;
  logic        rs_reg, rs_next;
  logic        start_reg, start_next;

  always_comb begin
    phase_next   = phase_reg;
    dly_cnt_next = dly_cnt_reg;
    data_next    = data_reg;
    rs_next      = rs_reg;
    start_next   = start_reg;
    case (phase_reg)
      HS_IDLE: begin
        if (go) begin
          data_next  = data;
          rs_next    = rs;
          start_next = 1'b1;
          phase_next = HS_WAIT;
        end
      end
      HS_WAIT: begin
        if (lcd_done) begin
          start_next   = 1'b0;
          dly_cnt_next = '0;
          phase_next   = HS_DELAY;
        end
      end
      HS_DELAY: begin
        if (dly_cnt_reg == DLY_LAST) begin
          dly_cnt_next = '0;
          phase_next   = HS_IDLE;
        end else begin
          dly_cnt_next = dly_cnt_reg + 18'd1;
        end
      end
      default: begin
        start_next = 1'b0;
        phase_next = HS_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      phase_reg   <= HS_IDLE;
      dly_cnt_reg <= '0;
      data_reg    <= '0;
      rs_reg      <= 1'b0;
      start_reg   <= 1'b0;
    end else begin
      phase_reg   <= phase_next;
      dly_cnt_reg <= dly_cnt_next;
      data_reg    <= data_next;
      rs_reg      <= rs_next;
      start_reg   <= start_next;
    end
  end

  assign lcd_data  = data_reg;
  assign lcd_rs    = rs_reg;
  assign lcd_start = start_reg;
  assign busy      = (phase_reg != HS_IDLE);
  assign item_done = (phase_reg == HS_DELAY) && (dly_cnt_reg == DLY_LAST);

endmodule

// File: rtl/lcd_page_sequencer.sv
// ---------------------------------------------------------------------------
// lcd_page_sequencer
// Drives the shared LCD_Controller handshake: sends the HD44780 init list
// after reset, then writes full 2x16 frames. A frame is redrawn whenever the
// selected page changes or iREFRESH pulses; a request arriving mid-frame
// restarts the frame at the next item boundary.
// Ports:
//   iCLK, iRST_N   clock, asynchronous active-low reset
//   iPAGE          page select (0..7)
//   iREFRESH       single-cycle redraw request
//   bus            lcd_page_sequencer_if.master (LCD handshake + content table)
//   oBUSY          high whenever the FSM is not idle
//   oFRAME_DONE    one-cycle pulse after the last character's settle delay
// Build option:
//   AUTO_REFRESH_EN  adds a free-running REFRESH_CYCLES timer that requests a
//                    redraw on each wrap (live counters on pages 6/7).
// ---------------------------------------------------------------------------
module lcd_page_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int DLY_CYCLES     = 262143,
  parameter int REFRESH_CYCLES = 50000000
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic [2:0]           iPAGE,
  input  logic                 iREFRESH,
  lcd_page_sequencer_if.master bus,
  output logic                 oBUSY,
  output logic                 oFRAME_DONE
);

  logic [2:0] state_reg, state_next;
  logic [5:0] item_reg, item_next;
  logic       init_phase_reg, init_phase_next;
  logic       pending_reg, pending_next;
  logic       init_req_reg, init_req_next;   // request seen during init
  logic [2:0] page_reg, page_next;
  logic [4:0] char_addr_reg, char_addr_next;
  logic       frame_done_reg, frame_done_next;
  logic       busy_reg, busy_next;

  logic       hs_go, hs_busy, hs_item_done;
  logic [7:0] item_data;
  logic       item_rs;
  logic       auto_wrap;

  // Init command table.
  logic [7:0] init_cmd [INIT_ITEMS];
  genvar gi;
  for (gi = 0; gi < INIT_ITEMS; gi++) begin : g_init_cmd
    assign init_cmd[gi] = INIT_CMDS[gi];
  end

  // Contents of the current item, sampled by the handshake in the ISSUE cycle.
  always_comb begin
    item_data = bus.char_code;
    item_rs   = 1'b1;
    if (init_phase_reg) begin
      item_data = init_cmd[item_reg[1:0]];
      item_rs   = 1'b0;
    end else if (item_reg == ITEM_LINE0) begin
      item_data = CMD_LINE0;
      item_rs   = 1'b0;
    end else if (item_reg == ITEM_LINE1) begin
      item_data = CMD_LINE1;
      item_rs   = 1'b0;
    end
  end

`ifdef AUTO_REFRESH_EN
  localparam int AR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [AR_W-1:0] AR_LAST = AR_W'(REFRESH_CYCLES - 1);

  logic [AR_W-1:0] ar_cnt_reg;

  assign auto_wrap = !init_phase_reg && (state_reg != ST_FRAME_START) &&
                     (ar_cnt_reg == AR_LAST);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)
      ar_cnt_reg <= '0;
    else if (init_phase_reg || state_reg == ST_FRAME_START || ar_cnt_reg == AR_LAST)
      ar_cnt_reg <= '0;
    else
      ar_cnt_reg <= ar_cnt_reg + 1'b1;
  end
`else
  logic unused_refresh_cfg;
  assign unused_refresh_cfg = (REFRESH_CYCLES > 0);
  assign auto_wrap = 1'b0;
`endif

  always_comb begin
    state_next      = state_reg;
    item_next       = item_reg;
    init_phase_next = init_phase_reg;
    pending_next    = pending_reg;
    init_req_next   = init_req_reg;
    page_next       = page_reg;
    char_addr_next  = char_addr_reg;
    frame_done_next = 1'b0;
    hs_go           = 1'b0;

    // Redraw requests. During init they are parked so the first frame runs
    // uninterrupted. In FRAME_START the page compare is meaningless because
    // the page register is being loaded in that same cycle.
    if (init_phase_reg)
      init_req_next = init_req_reg | iREFRESH;
    else if (state_reg == ST_FRAME_START)
      pending_next = iREFRESH | auto_wrap;
    else
      pending_next = pending_reg | iREFRESH | auto_wrap | (iPAGE != page_reg);

    case (state_reg)
      ST_INIT: begin
        item_next  = '0;
        state_next = ST_ISSUE;
      end
      ST_IDLE: begin
        if (pending_reg)
          state_next = ST_FRAME_START;
      end
      ST_FRAME_START: begin
        page_next      = iPAGE;
        item_next      = ITEM_LINE0;
        char_addr_next = '0;
        state_next     = ST_ISSUE;
      end
      ST_ISSUE: begin
        hs_go = !hs_busy;
        if (!hs_busy)
          state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.lcd_done)
          state_next = ST_DELAY;
      end
      ST_DELAY: begin
        if (hs_item_done)
          state_next = ST_NEXT;
      end
      ST_NEXT: begin
        if (init_phase_reg) begin
          if (item_reg == INIT_LAST) begin
            init_phase_next = 1'b0;
            state_next      = ST_FRAME_START;
          end else begin
            item_next  = item_reg + 6'd1;
            state_next = ST_ISSUE;
          end
        end else if (item_reg == ITEM_LAST) begin
          frame_done_next = 1'b1;
          init_req_next   = 1'b0;
          state_next      = (pending_reg || init_req_reg) ? ST_FRAME_START : ST_IDLE;
        end else if (pending_reg) begin
          // Restart the frame from its first line command.
          state_next = ST_FRAME_START;
        end else begin
          item_next      = item_reg + 6'd1;
          char_addr_next = item_char_addr(item_reg + 6'd1);
          state_next     = ST_ISSUE;
        end
      end
      default: state_next = ST_INIT;
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg      <= ST_INIT;
      item_reg       <= '0;
      init_phase_reg <= 1'b1;
      pending_reg    <= 1'b0;
      init_req_reg   <= 1'b0;
      page_reg       <= '0;
      char_addr_reg  <= '0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      item_reg       <= item_next;
      init_phase_reg <= init_phase_next;
      pending_reg    <= pending_next;
      init_req_reg   <= init_req_next;
      page_reg       <= page_next;
      char_addr_reg  <= char_addr_next;
      frame_done_reg <= frame_done_next;
      busy_reg       <= busy_next;
    end
  end

  lcd_item_handshake #(
    .DLY_CYCLES(DLY_CYCLES)
  ) u_handshake (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .go        (hs_go),
    .data      (item_data),
    .rs        (item_rs),
    .lcd_done  (bus.lcd_done),
    .lcd_data  (bus.lcd_data),
    .lcd_rs    (bus.lcd_rs),
    .lcd_start (bus.lcd_start),
    .busy      (hs_busy),
    .item_done (hs_item_done)
  );

  assign bus.page      = page_reg;
  assign bus.char_addr = char_addr_reg;
  assign oBUSY         = busy_reg;
  assign oFRAME_DONE   = frame_done_reg;

endmodule

// File: tb/tb_lcd_page_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lcd_page_sequencer
// Scoreboard bench: scenarios push the expected LCD item stream (built from
// the frame layout rules) into a queue; a monitor pops one entry on every
// rising edge of lcd_start. A controller model answers each start with done
// after a random 1..4 cycles and injects stray done pulses while idle.
// ---------------------------------------------------------------------------
module tb_lcd_page_sequencer;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    logic [2:0] page;
    logic [4:0] addr;
  } exp_t;

  logic       iCLK;
  logic       iRST_N;
  logic [2:0] iPAGE;
  logic       iREFRESH;
  logic       oBUSY;
  logic       oFRAME_DONE;

  lcd_page_sequencer_if bus();

  lcd_page_sequencer #(
    .DLY_CYCLES(4),
    .REFRESH_CYCLES(500)
  ) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iPAGE       (iPAGE),
    .iREFRESH    (iREFRESH),
    .bus         (bus),
    .oBUSY       (oBUSY),
    .oFRAME_DONE (oFRAME_DONE)
  );

  // Content table: 0x40 + position.
  assign bus.char_code = 8'h40 + {3'b000, bus.char_addr};

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   starts_seen = 0;
  int   fd_seen = 0;
  int   fd_exp = 0;
  int   cycle = 0;
  int   line0_cycles[$];
  logic [7:0] init_list [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  always @(posedge iCLK) cycle <= cycle + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push_init();
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{rs: 1'b0, data: init_list[i], page: 3'd0, addr: 5'd0});
  endtask

  // Frame items 0..last: line command, 16 chars, line command, 16 chars.
  task automatic push_frame(input logic [2:0] pg, input int last);
    for (int idx = 0; idx <= last; idx++) begin
      int line, col;
      if (idx == 0)
        exp_q.push_back('{rs: 1'b0, data: 8'h80, page: pg, addr: 5'd0});
      else if (idx == 17)
        exp_q.push_back('{rs: 1'b0, data: 8'hC0, page: pg, addr: 5'd0});
      else begin
        line = (idx > 17) ? 1 : 0;
        col  = (idx > 17) ? idx - 18 : idx - 1;
        exp_q.push_back('{rs: 1'b1, data: 8'(8'h40 + line * 16 + col),
                          page: pg, addr: 5'(line * 16 + col)});
      end
    end
  endtask

  // ---------------- controller model ----------------
  initial begin
    int cnt, lat;
    logic pulsed;
    bus.lcd_done = 1'b0;
    cnt = 0;
    pulsed = 1'b0;
    lat = int'($urandom_range(1, 4));
    forever begin
      @(negedge iCLK);
      if (pulsed) begin
        bus.lcd_done = 1'b0;
        pulsed = 1'b0;
      end else if (bus.lcd_start) begin
        cnt++;
        if (cnt >= lat) begin
          bus.lcd_done = 1'b1;
          pulsed = 1'b1;
          cnt = 0;
          lat = int'($urandom_range(1, 4));
        end
      end else begin
        cnt = 0;
        if ($urandom_range(0, 15) == 0) begin
          bus.lcd_done = 1'b1;  // stray done outside the wait phase
          pulsed = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic start_prev;
    exp_t e;
    start_prev = 1'b0;
    forever begin
      @(negedge iCLK);
      if (oFRAME_DONE) fd_seen++;
      if (bus.lcd_start && !start_prev) begin
        starts_seen++;
        if (bus.lcd_data == 8'h80) line0_cycles.push_back(cycle);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_item: got data=0x%0h rs=%0b, none expected",
                   bus.lcd_data, bus.lcd_rs);
        end else begin
          e = exp_q.pop_front();
          if (bus.lcd_data !== e.data || bus.lcd_rs !== e.rs || bus.page !== e.page ||
              (e.rs && bus.char_addr !== e.addr)) begin
            errors++;
            $display("FAIL item: got data=0x%0h rs=%0b page=%0d addr=%0d expected data=0x%0h rs=%0b page=%0d addr=%0d",
                     bus.lcd_data, bus.lcd_rs, bus.page, bus.char_addr,
                     e.data, e.rs, e.page, e.addr);
          end
        end
      end
      start_prev = bus.lcd_start;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((oBUSY || exp_q.size() != 0) && n < 6000) begin
      @(negedge iCLK);
      n++;
    end
    if (n >= 6000) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: busy=%0b queued=%0d after %0d cycles", name, oBUSY, exp_q.size(), n);
    end
    repeat (5) @(negedge iCLK);
  endtask

  task automatic wait_starts(input int target);
    int n;
    n = 0;
    while (starts_seen < target && n < 3000) begin
      @(negedge iCLK);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL start_timeout: seen=%0d expected=%0d", starts_seen, target);
    end
  endtask

  task automatic pulse_refresh();
    @(negedge iCLK) iREFRESH = 1'b1;
    @(negedge iCLK) iREFRESH = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [2:0] pg, newpg;
    int k, base;
    iRST_N = 1'b0;
    iPAGE = 3'd0;
    iREFRESH = 1'b0;
    repeat (3) @(negedge iCLK);
    chk("rst_start", bus.lcd_start, 0);
    chk("rst_data", bus.lcd_data, 0);
    chk("rst_rs", bus.lcd_rs, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_frame_done", oFRAME_DONE, 0);
    chk("rst_page", bus.page, 0);
    chk("rst_addr", bus.char_addr, 0);

`ifdef AUTO_REFRESH_EN
    push_init();
    for (int f = 0; f < 6; f++) push_frame(3'd0, 33);
    fd_exp = 6;
    iRST_N = 1'b1;
    wait_idle("auto");
    chk("auto_frame_done", fd_seen, fd_exp);
    chk("auto_frames", line0_cycles.size(), 6);
    for (int i = 1; i < line0_cycles.size(); i++) begin
      int d;
      d = line0_cycles[i] - line0_cycles[i-1];
      chk("auto_interval_ok", int'(d >= 500 && d <= 504), 1);
    end
`else
    // Power-up: init list then one full frame of page 0.
    push_init();
    push_frame(3'd0, 33);
    fd_exp++;
    iRST_N = 1'b1;
    wait_idle("powerup");
    chk("powerup_busy", oBUSY, 0);
    chk("powerup_frame_done", fd_seen, fd_exp);
    pg = 3'd0;

    // Page changes while idle: 2 first, then random distinct pages.
    for (int i = 0; i < 3; i++) begin
      newpg = (i == 0) ? 3'd2 : 3'(pg + 3'(1 + $urandom_range(0, 6)));
      push_frame(newpg, 33);
      fd_exp++;
      @(negedge iCLK) iPAGE = newpg;
      wait_idle("page");
      pg = newpg;
      chk("page_latched", bus.page, pg);
      chk("page_frame_done", fd_seen, fd_exp);
    end

    // Refresh during item k: item k finishes, then the frame restarts at 0x80.
    for (int i = 0; i < 4; i++) begin
      k = (i == 0) ? 10 : (i == 1) ? 33 : int'($urandom_range(0, 32));
      base = starts_seen;
      push_frame(pg, k);
      pulse_refresh();
      wait_starts(base + k + 1);
      @(negedge iCLK) iREFRESH = 1'b1;
      @(negedge iCLK) iREFRESH = 1'b0;
      if (k == 33) fd_exp++;
      push_frame(pg, 33);
      fd_exp++;
      wait_idle("abort");
      chk("abort_frame_done", fd_seen, fd_exp);
    end

    // Refresh + page change together, then another refresh in FRAME_START:
    // the pending request survives, so item 0 is followed by a restart.
    newpg = 3'(pg + 3'(1 + $urandom_range(0, 6)));
    push_frame(newpg, 0);
    push_frame(newpg, 33);
    fd_exp++;
    @(negedge iCLK) begin iPAGE = newpg; iREFRESH = 1'b1; end
    @(negedge iCLK) iREFRESH = 1'b0;
    @(negedge iCLK) iREFRESH = 1'b1;
    @(negedge iCLK) iREFRESH = 1'b0;
    wait_idle("simul");
    pg = newpg;
    chk("simul_page", bus.page, pg);
    chk("simul_frame_done", fd_seen, fd_exp);

    // Reset during WAIT of item 20, plus a refresh during the re-sent init.
    base = starts_seen;
    push_frame(pg, 20);
    pulse_refresh();
    wait_starts(base + 21);
    chk("pre_reset_start", bus.lcd_start, 1);
    iRST_N = 1'b0;
    #1;
    chk("reset_start_low", bus.lcd_start, 0);
    chk("reset_page", bus.page, 0);
    chk("reset_busy", oBUSY, 0);
    push_init();
    push_frame(pg, 33);
    push_frame(pg, 33);
    fd_exp += 2;
    base = starts_seen;
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    wait_starts(base + 2);
    pulse_refresh();
    wait_idle("reset");
    chk("reset_frame_done", fd_seen, fd_exp);
    chk("reset_page_after", bus.page, pg);

    // Quiet period: without auto-refresh nothing more is drawn.
    repeat (1200) @(negedge iCLK);
    chk("quiet_busy", oBUSY, 0);
    chk("quiet_frame_done", fd_seen, fd_exp);
`endif
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
